// File: rtl/wb_pkg.sv
// Shared write-back definitions.
// Purpose : the write-back entry record used between the execute-unit
//           write-back channels and the single registered write-back channel.
// Contents: WB_RDADDR_W / WB_CAUSE_W field widths, default tag/data widths,
//           wb_entry_t record.
package wb_pkg;

    localparam int WB_RDADDR_W = 5;
    localparam int WB_CAUSE_W  = 5;
    localparam int WB_ITAG_W   = 8;
    localparam int WB_XLEN     = 64;

    typedef struct packed {
        logic [WB_ITAG_W-1:0]   itag;
        logic [WB_XLEN-1:0]     data;
        logic                   rd_wen;
        logic [WB_RDADDR_W-1:0] rd_addr;
        logic                   exc;
        logic [WB_CAUSE_W-1:0]  cause;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter with a registered priority pointer.
// Purpose : grants the first requesting source found scanning cyclically
//           from the pointer; after a granted transfer the pointer moves
//           to one past the winner.
// Ports   : clk_i, arst_i (async, active-high)
//           req[NPORT]     request vector
//           advance        a transfer happened on the current grant
//           grant[NPORT]   one-hot (or zero) grant
//           grant_idx      index of the granted source (0 when none)
module rr_arbiter #(
    parameter int NPORT = 4,
    parameter int IDX_W = $clog2(NPORT)
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [NPORT-1:0] req,
    input  logic             advance,
    output logic [NPORT-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] next_ptr;
    logic             found;

    // Index ptr+k folded back into 0..NPORT-1 (k < NPORT, so one subtraction suffices).
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        int r;
        r = v;
        if (r >= NPORT) r = r - NPORT;
        return IDX_W'(r);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = wrap_idx(int'(ptr_q) + k);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // Explicit wrap keeps ptr inside 0..NPORT-1 for non-power-of-two NPORT.
    assign next_ptr = (grant_idx == IDX_W'(NPORT - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter.
// Purpose : selects one completed micro-op per cycle from NPORT execute-unit
//           channels (round-robin) and registers it onto the single
//           write-back channel feeding ROB completion and regfile write.
//           A flush kills the registered entry and blocks acceptance.
// Ports   : clk_i, arst_i (async, active-high), flush_i
//           in_valid_i/in_ready_o and packed per-source payload
//             (itag, data, rd_wen, rd_addr, exc, cause), source i at [i*W +: W]
//           out_valid_o/out_ready_i and registered payload; out_rd_wen_o is
//           qualified by !exc; out_src_o is the winning source index.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NPORT  = 4,
    parameter int ITAG_W = 8,
    parameter int XLEN   = 64,
    parameter int IDX_W  = $clog2(NPORT)
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      flush_i,
    input  logic [NPORT-1:0]          in_valid_i,
    output logic [NPORT-1:0]          in_ready_o,
    input  logic [NPORT*ITAG_W-1:0]   in_itag_i,
    input  logic [NPORT*XLEN-1:0]     in_data_i,
    input  logic [NPORT-1:0]          in_rd_wen_i,
    input  logic [NPORT*5-1:0]        in_rd_addr_i,
    input  logic [NPORT-1:0]          in_exc_i,
    input  logic [NPORT*5-1:0]        in_cause_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ITAG_W-1:0]         out_itag_o,
    output logic [XLEN-1:0]           out_data_o,
    output logic                      out_rd_wen_o,
    output logic [4:0]                out_rd_addr_o,
    output logic                      out_exc_o,
    output logic [4:0]                out_cause_o,
    output logic [IDX_W-1:0]          out_src_o
);

    // The entry record has fixed widths; the parameters must agree with it.
    if ((ITAG_W != WB_ITAG_W) || (XLEN != WB_XLEN)) begin : g_param_check
        $error("wb_arbiter: ITAG_W/XLEN must match wb_pkg entry widths");
    end

    wb_entry_t        ent [NPORT];
    wb_entry_t        sel;
    logic [NPORT-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;

    wb_entry_t        entry_p1;
    logic [IDX_W-1:0] src_p1;
    logic             vld_p1;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            ent[i].itag    = in_itag_i[i*ITAG_W +: ITAG_W];
            ent[i].data    = in_data_i[i*XLEN +: XLEN];
            ent[i].rd_wen  = in_rd_wen_i[i];
            ent[i].rd_addr = in_rd_addr_i[i*WB_RDADDR_W +: WB_RDADDR_W];
            ent[i].exc     = in_exc_i[i];
            ent[i].cause   = in_cause_i[i*WB_CAUSE_W +: WB_CAUSE_W];
        end
    end

    // Output slot can take a new entry when empty or draining this cycle;
    // a flush blocks acceptance outright.
    assign load_en    = !(vld_p1 && !out_ready_i) && !flush_i;
    assign in_ready_o = grant & {NPORT{load_en}};
    assign xfer       = load_en && (|grant);

    rr_arbiter #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .req       (in_valid_i),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // An excepting micro-op must not write the register file.
    always_comb begin
        sel        = ent[grant_idx];
        sel.rd_wen = ent[grant_idx].rd_wen && !ent[grant_idx].exc;
    end

    // ---- stage boundary: arbitration -> registered write-back entry ----
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            vld_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (load_en) begin
            vld_p1 <= xfer;
        end
    end

    always_ff @(posedge clk_i) begin
        if (xfer) begin
            entry_p1 <= sel;
            src_p1   <= grant_idx;
        end
    end

    assign out_valid_o   = vld_p1;
    assign out_itag_o    = entry_p1.itag;
    assign out_data_o    = entry_p1.data;
    assign out_rd_wen_o  = entry_p1.rd_wen;
    assign out_rd_addr_o = entry_p1.rd_addr;
    assign out_exc_o     = entry_p1.exc;
    assign out_cause_o   = entry_p1.cause;
    assign out_src_o     = src_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (NPORT=4, ITAG_W=8, XLEN=64).
module tb_wb_arbiter;

    localparam int NPORT  = 4;
    localparam int ITAG_W = 8;
    localparam int XLEN   = 64;

    logic                    clk_i = 1'b0;
    logic                    arst_i;
    logic                    flush_i;
    logic [NPORT-1:0]        in_valid_i;
    logic [NPORT-1:0]        in_ready_o;
    logic [NPORT*ITAG_W-1:0] in_itag_i;
    logic [NPORT*XLEN-1:0]   in_data_i;
    logic [NPORT-1:0]        in_rd_wen_i;
    logic [NPORT*5-1:0]      in_rd_addr_i;
    logic [NPORT-1:0]        in_exc_i;
    logic [NPORT*5-1:0]      in_cause_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [ITAG_W-1:0]       out_itag_o;
    logic [XLEN-1:0]         out_data_o;
    logic                    out_rd_wen_o;
    logic [4:0]              out_rd_addr_o;
    logic                    out_exc_o;
    logic [4:0]              out_cause_o;
    logic [1:0]              out_src_o;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(.NPORT(NPORT), .ITAG_W(ITAG_W), .XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_itag_i     (in_itag_i),
        .in_data_i     (in_data_i),
        .in_rd_wen_i   (in_rd_wen_i),
        .in_rd_addr_i  (in_rd_addr_i),
        .in_exc_i      (in_exc_i),
        .in_cause_i    (in_cause_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_itag_o    (out_itag_o),
        .out_data_o    (out_data_o),
        .out_rd_wen_o  (out_rd_wen_o),
        .out_rd_addr_o (out_rd_addr_o),
        .out_exc_o     (out_exc_o),
        .out_cause_o   (out_cause_o),
        .out_src_o     (out_src_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [7:0] itag, input logic [63:0] data,
                           input logic wen, input logic [4:0] rd, input logic exc,
                           input logic [4:0] cause);
        in_itag_i[i*ITAG_W +: ITAG_W] = itag;
        in_data_i[i*XLEN +: XLEN]     = data;
        in_rd_wen_i[i]                = wen;
        in_rd_addr_i[i*5 +: 5]        = rd;
        in_exc_i[i]                   = exc;
        in_cause_i[i*5 +: 5]          = cause;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1; in_valid_i = '0;
        in_itag_i = '0; in_data_i = '0; in_rd_wen_i = '0; in_rd_addr_i = '0;
        in_exc_i = '0; in_cause_i = '0;
        for (int i = 0; i < NPORT; i++)
            set_src(i, 8'(8'h10 + i), 64'(64'hD000 + i), 1'b1, 5'(i + 1), 1'b0, 5'd0);
        #12;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_ptr", 64'(dut.u_rr.ptr_q), 64'd0);
        arst_i = 1'b0;
        step();

        // 1: source 2 alone
        set_src(2, 8'h15, 64'hDEAD, 1'b1, 5'd7, 1'b0, 5'd0);
        in_valid_i = 4'b0100;
        #1;
        chk("t1_ready", 64'(in_ready_o), 64'b0100);
        step();
        in_valid_i = '0;
        chk("t1_valid", 64'(out_valid_o), 64'd1);
        chk("t1_itag", 64'(out_itag_o), 64'h15);
        chk("t1_data", out_data_o, 64'hDEAD);
        chk("t1_wen", 64'(out_rd_wen_o), 64'd1);
        chk("t1_rd", 64'(out_rd_addr_o), 64'd7);
        chk("t1_src", 64'(out_src_o), 64'd2);
        chk("t1_ptr", 64'(dut.u_rr.ptr_q), 64'd3);
        step();
        chk("t1_drain", 64'(out_valid_o), 64'd0);

        // move pointer to 0 via source 3
        set_src(2, 8'h12, 64'hD002, 1'b1, 5'd3, 1'b0, 5'd0);
        in_valid_i = 4'b1000;
        step();
        chk("t2_ptr0", 64'(dut.u_rr.ptr_q), 64'd0);

        // 2: all sources valid, back-to-back grants 0,1,2,3,0
        in_valid_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2_ready%0d", k), 64'(in_ready_o), 64'(4'b0001 << (k % 4)));
            step();
            chk($sformatf("t2_valid%0d", k), 64'(out_valid_o), 64'd1);
            chk($sformatf("t2_src%0d", k), 64'(out_src_o), 64'(k % 4));
            chk($sformatf("t2_itag%0d", k), 64'(out_itag_o), 64'(8'h10 + (k % 4)));
        end
        chk("t2_ptr", 64'(dut.u_rr.ptr_q), 64'd1);

        // 3: source 1 with exception
        set_src(1, 8'h21, 64'h1111, 1'b1, 5'd9, 1'b1, 5'd13);
        in_valid_i = 4'b0010;
        step();
        chk("t3_exc", 64'(out_exc_o), 64'd1);
        chk("t3_cause", 64'(out_cause_o), 64'd13);
        chk("t3_wen", 64'(out_rd_wen_o), 64'd0);
        chk("t3_src", 64'(out_src_o), 64'd1);

        // 4: stall 3 cycles with sources 0 and 3 valid; ptr=2
        out_ready_i = 1'b0;
        in_valid_i = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_ready%0d", k), 64'(in_ready_o), 64'd0);
            chk($sformatf("t4_valid%0d", k), 64'(out_valid_o), 64'd1);
            chk($sformatf("t4_itag%0d", k), 64'(out_itag_o), 64'h21);
            step();
        end
        chk("t4_ptr_hold", 64'(dut.u_rr.ptr_q), 64'd2);
        out_ready_i = 1'b1;
        #1;
        chk("t4_ready_go", 64'(in_ready_o), 64'b1000);
        step();
        chk("t4_src", 64'(out_src_o), 64'd3);
        chk("t4_itag", 64'(out_itag_o), 64'h13);
        chk("t4_ptr", 64'(dut.u_rr.ptr_q), 64'd0);

        // 5: flush while stalled, source 0 valid
        out_ready_i = 1'b0;
        in_valid_i = 4'b0001;
        flush_i = 1'b1;
        #1;
        chk("t5_ready_flush", 64'(in_ready_o), 64'd0);
        step();
        flush_i = 1'b0;
        chk("t5_valid", 64'(out_valid_o), 64'd0);
        chk("t5_ptr", 64'(dut.u_rr.ptr_q), 64'd0);
        #1;
        chk("t5_ready_after", 64'(in_ready_o), 64'b0001);
        step();
        chk("t5_valid2", 64'(out_valid_o), 64'd1);
        chk("t5_src", 64'(out_src_o), 64'd0);
        chk("t5_ptr2", 64'(dut.u_rr.ptr_q), 64'd1);

        // 6: async reset mid-stream with ptr=2, out valid
        out_ready_i = 1'b1;
        in_valid_i = 4'b0010;
        step();
        in_valid_i = '0;
        chk("t6_pre_valid", 64'(out_valid_o), 64'd1);
        chk("t6_pre_ptr", 64'(dut.u_rr.ptr_q), 64'd2);
        #2;
        arst_i = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid_o), 64'd0);
        chk("t6_rst_ptr", 64'(dut.u_rr.ptr_q), 64'd0);
        step();
        #2;
        arst_i = 1'b0;
        in_valid_i = 4'b0101;
        #1;
        chk("t6_ready", 64'(in_ready_o), 64'b0001);
        step();
        chk("t6_src", 64'(out_src_o), 64'd0);
        chk("t6_valid", 64'(out_valid_o), 64'd1);
        in_valid_i = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
